// File: rtl/etherneco_synctimer_master_cmd.sv
// Master-side sync-timer command stream generator and response collector for the etherneco ring.
// Optional feature: define ETHERNECO_SYNCTIMER_MASTER_LPF_EN to low-pass filter offset commits.
module etherneco_synctimer_master_cmd #(
  parameter int TIMER_WIDTH  = 64,
  parameter int NODE_MAX     = 8,
  parameter int PERIOD_WIDTH = 32,
  parameter int OFFSET_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    override_req,
  input  logic [PERIOD_WIDTH-1:0] param_period,
  input  logic [7:0]              node_count,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  output logic                    tx_start,
  output logic                    m_cmd_first,
  output logic                    m_cmd_last,
  output logic [7:0]              m_cmd_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  input  logic                    res_rx_start,
  input  logic                    res_rx_end,
  input  logic                    res_rx_error,
  input  logic [15:0]             s_res_pos,
  input  logic [7:0]              s_res_data,
  input  logic                    s_res_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]              state_r, state_s;
  logic [PERIOD_WIDTH-1:0] cnt_r, period_eff_s;
  logic                    term_s, launch_s, hs_s, last_hs_s, present_s;
  logic [7:0]              n_r, n_clamp_s, cmd_r;
  logic [63:0]             time_ext_s, time_r;
  logic [OFFSET_WIDTH-1:0] t0_r, rtt_r, sel_off_s;
  logic [15:0]             pos_r, pres_pos_s, last_pos_s, off_idx_s, rsp_idx_s;
  logic [7:0]              pres_byte_s, tbyte_s;
  logic                    override_pend_r, rx_active_r, rsp_hit_s;
  logic [OFFSET_WIDTH-1:0] offset_r  [NODE_MAX];
  logic [OFFSET_WIDTH-1:0] staging_r [NODE_MAX];
  logic [OFFSET_WIDTH-1:0] new_off_s [NODE_MAX];
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
  logic                    first_commit_r;
  logic [OFFSET_WIDTH-1:0] lpf_off_s [NODE_MAX];
`endif

  assign time_ext_s   = 64'(current_time);
  assign period_eff_s = (param_period == '0) ? PERIOD_WIDTH'(1) : param_period;
  assign term_s       = (cnt_r >= (period_eff_s - PERIOD_WIDTH'(1)));
  assign hs_s         = m_cmd_valid && m_cmd_ready;
  assign last_hs_s    = hs_s && m_cmd_last;
  // A late frame may launch its successor on the very edge of its final handshake.
  assign launch_s     = enable && term_s &&
                        ((state_r == ST_WAIT) || ((state_r == ST_SEND) && last_hs_s));
  assign present_s    = (state_r == ST_SEND) && (!m_cmd_valid || (hs_s && !m_cmd_last));
  assign pres_pos_s   = m_cmd_valid ? (pos_r + 16'd1) : pos_r;
  assign last_pos_s   = 16'd8 + {6'd0, n_r, 2'b00};
  assign off_idx_s    = pres_pos_s - 16'd9;
  assign rsp_idx_s    = s_res_pos - 16'd9;
  assign rsp_hit_s    = s_res_valid && (s_res_pos >= 16'd9) && (rsp_idx_s[15:2] < {6'd0, n_r});

  // Node count clamp to 1..NODE_MAX
  always_comb begin
    n_clamp_s = node_count;
    if (node_count == 8'd0) begin
      n_clamp_s = 8'd1;
    end else if (node_count > 8'(NODE_MAX)) begin
      n_clamp_s = 8'(NODE_MAX);
    end else begin
      n_clamp_s = node_count;
    end
  end

  // Frame sequencing
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (launch_s) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (!last_hs_s) begin
          state_s = ST_SEND;
        end else if (launch_s) begin
          state_s = ST_SEND;
        end else if (!enable) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Byte at the position about to be presented; offsets are read live
  always_comb begin
    tbyte_s     = 8'h00;
    sel_off_s   = '0;
    pres_byte_s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tbyte_s = (pres_pos_s[3:0] == 4'(i + 1)) ? time_r[8*i +: 8] : tbyte_s;
    end
    for (int k = 0; k < NODE_MAX; k++) begin
      sel_off_s = (off_idx_s[15:2] == 14'(k)) ? offset_r[k] : sel_off_s;
    end
    if (pres_pos_s == 16'd0) begin
      pres_byte_s = cmd_r;
    end else if (pres_pos_s < 16'd9) begin
      pres_byte_s = tbyte_s;
    end else begin
      case (off_idx_s[1:0])
        2'd0:    pres_byte_s = sel_off_s[7:0];
        2'd1:    pres_byte_s = sel_off_s[15:8];
        2'd2:    pres_byte_s = sel_off_s[23:16];
        2'd3:    pres_byte_s = sel_off_s[31:24];
        default: pres_byte_s = 8'h00;
      endcase
    end
  end

  // Candidate offsets from the staged elapsed times
  always_comb begin
    for (int k = 0; k < NODE_MAX; k++) begin
      new_off_s[k] = (rtt_r - staging_r[k]) >> 1;
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
      lpf_off_s[k] = offset_r[k] + OFFSET_WIDTH'($signed(new_off_s[k] - offset_r[k]) >>> 2);
`endif
    end
  end

  // Period counter, frame launch and payload streaming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      cnt_r           <= '0;
      tx_start        <= 1'b0;
      m_cmd_valid     <= 1'b0;
      m_cmd_first     <= 1'b0;
      m_cmd_last      <= 1'b0;
      m_cmd_data      <= 8'h00;
      pos_r           <= 16'd0;
      n_r             <= 8'd1;
      time_r          <= 64'd0;
      t0_r            <= '0;
      cmd_r           <= 8'h00;
      override_pend_r <= 1'b1;
    end else begin
      state_r  <= state_s;
      tx_start <= launch_s;
      if (launch_s || (state_r == ST_IDLE)) begin
        cnt_r <= '0;
      end else if (!term_s) begin
        cnt_r <= cnt_r + PERIOD_WIDTH'(1);
      end
      override_pend_r <= launch_s ? 1'b0 : (override_pend_r | override_req);
      if (launch_s) begin
        n_r    <= n_clamp_s;
        time_r <= time_ext_s;
        t0_r   <= time_ext_s[OFFSET_WIDTH-1:0];
        cmd_r  <= {6'b0, override_pend_r | override_req, enable};
        pos_r  <= 16'd0;
      end
      if (present_s) begin
        m_cmd_valid <= 1'b1;
        m_cmd_data  <= pres_byte_s;
        m_cmd_first <= (pres_pos_s == 16'd0);
        m_cmd_last  <= (pres_pos_s == last_pos_s);
        pos_r       <= pres_pos_s;
      end else if (last_hs_s) begin
        m_cmd_valid <= 1'b0;
        m_cmd_first <= 1'b0;
        m_cmd_last  <= 1'b0;
      end
    end
  end

  // Response capture, round-trip time and offset table commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rtt_r       <= '0;
      rx_active_r <= 1'b0;
      for (int k = 0; k < NODE_MAX; k++) begin
        offset_r[k]  <= '0;
        staging_r[k] <= '0;
      end
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
      first_commit_r <= 1'b1;
`endif
    end else begin
      if (res_rx_start) begin
        rtt_r       <= time_ext_s[OFFSET_WIDTH-1:0] - t0_r;
        rx_active_r <= 1'b1;
      end
      if (res_rx_error) begin
        rx_active_r <= 1'b0;
        for (int k = 0; k < NODE_MAX; k++) begin
          staging_r[k] <= '0;
        end
      end else if (res_rx_end && rx_active_r) begin
        rx_active_r <= 1'b0;
        for (int k = 0; k < NODE_MAX; k++) begin
          staging_r[k] <= '0;
          if (8'(k) < n_r) begin
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
            offset_r[k] <= first_commit_r ? new_off_s[k] : lpf_off_s[k];
`else
            offset_r[k] <= new_off_s[k];
`endif
          end
        end
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
        first_commit_r <= 1'b0;
`endif
      end else if (rsp_hit_s) begin
        for (int k = 0; k < NODE_MAX; k++) begin
          for (int b = 0; b < 4; b++) begin
            if ((rsp_idx_s[15:2] == 14'(k)) && (rsp_idx_s[1:0] == 2'(b))) begin
              staging_r[k][8*b +: 8] <= s_res_data;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_etherneco_synctimer_master_cmd.sv
// Self-checking bench: a frame-level model predicts every streamed byte and frame start time.
module tb_etherneco_synctimer_master_cmd;
  localparam logic [63:0] CT = 64'h1122334455667788;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, override_req = 1'b0;
  logic [31:0] param_period = 32'd0;
  logic [7:0]  node_count = 8'd0;
  logic [63:0] current_time = 64'd0;
  logic        tx_start, m_cmd_first, m_cmd_last, m_cmd_valid;
  logic [7:0]  m_cmd_data;
  logic        m_cmd_ready = 1'b0;
  logic        res_rx_start = 1'b0, res_rx_end = 1'b0, res_rx_error = 1'b0;
  logic [15:0] s_res_pos = 16'd0;
  logic [7:0]  s_res_data = 8'd0;
  logic        s_res_valid = 1'b0;

  always #5 clk = ~clk;

  etherneco_synctimer_master_cmd dut (
    .clk(clk), .reset(reset), .enable(enable), .override_req(override_req),
    .param_period(param_period), .node_count(node_count), .current_time(current_time),
    .tx_start(tx_start), .m_cmd_first(m_cmd_first), .m_cmd_last(m_cmd_last),
    .m_cmd_data(m_cmd_data), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .res_rx_start(res_rx_start), .res_rx_end(res_rx_end), .res_rx_error(res_rx_error),
    .s_res_pos(s_res_pos), .s_res_data(s_res_data), .s_res_valid(s_res_valid)
  );

  int n_checks = 0, n_fail = 0;
  logic [31:0] model_off [8] = '{default: 32'd0};
  logic        ovr_pend = 1'b1;
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
  logic        model_first = 1'b1;
`endif
  logic [7:0]  exp_b [64];
  logic [7:0]  got [64];
  logic [7:0]  cmd_hist [64];
  int exp_len = 0, idx = 0, got_len = 0, cyc = 0, frames_done = 0, tx_count = 0;
  int prev_tx = 0, last_end = 0;
  bit have_prev = 1'b0, chk_valid_next = 1'b0, prev_stall = 1'b0, rnd_ready = 1'b0;
  logic [9:0] prev_out = 10'd0;

  task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got_v, exp_v, $time);
    end
  endtask

  function automatic int clampn(input logic [7:0] n);
    if (n == 8'd0) return 1;
    if (n > 8'd8) return 8;
    return int'(n);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: compares every cycle's stream behaviour against the frame model
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (prev_stall) begin
        chk("stall_hold", 64'({m_cmd_valid, m_cmd_first, m_cmd_last, m_cmd_data}), 64'({1'b1, prev_out}));
      end
      if (chk_valid_next) begin
        chk("first_valid_latency", 64'(m_cmd_valid), 64'd1);
        chk_valid_next = 1'b0;
      end
      if (tx_start) begin
        int n;
        chk("valid_at_tx", 64'(m_cmd_valid), 64'd0);
        chk("frame_done_before_tx", 64'(idx), 64'(exp_len));
        if (have_prev) begin
          chk("tx_spacing", 64'(cyc),
              64'(imax(prev_tx + ((param_period == 32'd0) ? 1 : int'(param_period)), last_end + 1)));
        end
        n = clampn(node_count);
        exp_len = 9 + 4 * n;
        exp_b[0] = {6'b0, ovr_pend, 1'b1};
        ovr_pend = 1'b0;
        for (int i = 0; i < 8; i++) exp_b[1 + i] = 8'(current_time >> (8 * i));
        for (int k = 0; k < n; k++)
          for (int b = 0; b < 4; b++) exp_b[9 + 4 * k + b] = 8'(model_off[k] >> (8 * b));
        idx = 0;
        prev_tx = cyc;
        have_prev = 1'b1;
        chk_valid_next = 1'b1;
        tx_count++;
      end
      if (m_cmd_valid && m_cmd_ready) begin
        if (idx >= exp_len) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got %0h with no byte expected", m_cmd_data);
        end else begin
          chk("byte", 64'({m_cmd_first, m_cmd_last, m_cmd_data}),
              64'({idx == 0, idx == exp_len - 1, exp_b[idx]}));
          got[idx] = m_cmd_data;
          idx++;
          if (idx == exp_len) begin
            got_len = idx;
            cmd_hist[frames_done % 64] = got[0];
            frames_done++;
            last_end = cyc;
          end
        end
      end
      prev_stall = m_cmd_valid && !m_cmd_ready;
      prev_out = {m_cmd_first, m_cmd_last, m_cmd_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) m_cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int t = 0;
    while (frames_done < target && t < 3000) begin tick(); t++; end
    if (frames_done < target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frames: got %0d frames expected %0d", frames_done, target);
    end
  endtask

  task automatic wait_tx();
    int target = tx_count + 1;
    int t = 0;
    while (tx_count < target && t < 3000) begin tick(); t++; end
    if (tx_count < target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_tx: got %0d starts expected %0d", tx_count, target);
    end
  endtask

  task automatic set_phase(input logic [31:0] p, input logic [7:0] n);
    rnd_ready = 1'b0;
    m_cmd_ready = 1'b1;
    enable = 1'b0;
    repeat (150) tick();
    param_period = p;
    node_count = n;
    have_prev = 1'b0;
    enable = 1'b1;
  endtask

  // mode 0: clean end, 1: error then a stray end, 2: end and error together
  task automatic do_resp(input int mode, input logic [31:0] e0, input logic [31:0] e1);
    logic [31:0] nv;
    wait_tx();
    repeat (25) tick();
    current_time = CT + 64'd400;
    res_rx_start = 1'b1;
    tick();
    res_rx_start = 1'b0;
    current_time = CT;
    for (int p = 0; p < 21; p++) begin
      s_res_valid = 1'b1;
      s_res_pos = 16'(p);
      s_res_data = (p >= 9 && p < 17) ? 8'(((p < 13) ? e0 : e1) >> (8 * ((p - 9) % 4))) : 8'hEE;
      tick();
    end
    s_res_valid = 1'b0;
    if (mode == 0) begin
      res_rx_end = 1'b1; tick(); res_rx_end = 1'b0;
      for (int k = 0; k < 2; k++) begin
        nv = (32'd400 - ((k == 0) ? e0 : e1)) >> 1;
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
        model_off[k] = model_first ? nv : model_off[k] + 32'($signed(nv - model_off[k]) >>> 2);
`else
        model_off[k] = nv;
`endif
      end
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
      model_first = 1'b0;
`endif
    end else if (mode == 1) begin
      res_rx_error = 1'b1; tick(); res_rx_error = 1'b0; tick();
      res_rx_end = 1'b1; tick(); res_rx_end = 1'b0;
    end else begin
      res_rx_end = 1'b1; res_rx_error = 1'b1; tick();
      res_rx_end = 1'b0; res_rx_error = 1'b0;
    end
  endtask

  initial begin
    int fk;
    repeat (3) tick();
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_valid", 64'(m_cmd_valid), 64'd0);
    chk("rst_first", 64'(m_cmd_first), 64'd0);
    chk("rst_last", 64'(m_cmd_last), 64'd0);
    chk("rst_data", 64'(m_cmd_data), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_no_tx", 64'(tx_start), 64'd0);

    param_period = 32'd100; node_count = 8'd2; current_time = CT; m_cmd_ready = 1'b1;
    enable = 1'b1;
    wait_frames(1);
    chk("f1_cmd_override", 64'(got[0]), 64'h03);
    chk("f1_time_lsb", 64'(got[1]), 64'h88);
    chk("f1_time_b2", 64'(got[2]), 64'h77);
    chk("f1_time_msb", 64'(got[8]), 64'h11);
    chk("f1_len", 64'(got_len), 64'd17);
    wait_frames(1);
    chk("f2_cmd_plain", 64'(got[0]), 64'h01);

    do_resp(1, 32'd100, 32'd300);
    wait_frames(1);
    chk("err_no_commit", 64'(got[9]), 64'h00);
    do_resp(2, 32'd100, 32'd300);
    wait_frames(1);
    chk("err_end_same_cycle", 64'(got[9]), 64'h00);
    do_resp(0, 32'd100, 32'd300);
    wait_frames(1);
    chk("off0_b0", 64'(got[9]), 64'h96);
    chk("off0_b1", 64'(got[10]), 64'h00);
    chk("off1_b0", 64'(got[13]), 64'h32);

    set_phase(32'd10, 8'd2);
    rnd_ready = 1'b1;
    wait_frames(2);
    wait_tx();
    fk = frames_done;
    repeat (3) tick();
    override_req = 1'b1; tick(); override_req = 1'b0;
    ovr_pend = 1'b1;
    wait_frames(2);
    chk("ovr_current_frame", 64'(cmd_hist[fk % 64]), 64'h01);
    chk("ovr_next_frame", 64'(cmd_hist[(fk + 1) % 64]), 64'h03);
    wait_frames(3);

    set_phase(32'd0, 8'd2);
    wait_frames(3);
    set_phase(32'd60, 8'd0);
    wait_frames(1);
    chk("clamp_low_len", 64'(got_len), 64'd13);
    set_phase(32'd60, 8'd20);
    wait_frames(1);
    chk("clamp_high_len", 64'(got_len), 64'd41);

    wait_tx();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(m_cmd_valid), 64'd0);
    chk("rst_mid_flags", 64'({tx_start, m_cmd_first, m_cmd_last}), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
